// File: rtl/led_pattern_ctrl.sv
// Button/LED demo controller: debounces active-low buttons on a prescaled tick and
// drives LEDs in one of four pattern modes; pressing all buttons together steps the mode.
module led_pattern_ctrl #(
    parameter int N_CH          = 2,
    parameter int DIV_W         = 12,
    parameter int DEB_TICKS     = 4,
    parameter int HALF_TICKS    = 12207,
    parameter int LOCKOUT_TICKS = 16384,
    parameter int RESET_MODE    = 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [N_CH-1:0] but_n,
    output logic [N_CH-1:0] led,
    output logic [1:0]      mode,
    output logic            tick
);

    localparam int DC_W = $clog2(DEB_TICKS + 1);
    localparam int PC_W = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
    localparam int LK_W = $clog2(LOCKOUT_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_PRE   = {DIV_W{1'b1}} - DIV_W'(1);
    localparam logic [DC_W-1:0]  DEB_LAST  = DC_W'(DEB_TICKS - 1);
    localparam logic [PC_W-1:0]  PHASE_LAST = PC_W'(HALF_TICKS - 1);
    localparam logic [LK_W-1:0]  LOCK_FULL = LK_W'(LOCKOUT_TICKS);
    localparam logic [N_CH-1:0]  CHASE_INIT = N_CH'(1);

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'd0,
        MODE_ALTERNATE = 2'd1,
        MODE_CHASE     = 2'd2,
        MODE_ALL_BLINK = 2'd3
    } mode_t;

    logic [DIV_W-1:0] div_reg;
    logic             tick_reg;
    logic [N_CH-1:0]  deb_vec;
    logic [N_CH-1:0]  alt_pat;
    logic [N_CH-1:0]  chase_reg;
    logic [N_CH-1:0]  chase_rot;
    logic [PC_W-1:0]  phase_cnt_reg;
    logic             phase_reg;
    logic [LK_W-1:0]  lock_cnt_reg;
    mode_t            mode_reg;
    logic [N_CH-1:0]  led_reg;
    logic [N_CH-1:0]  led_next;
    logic             combo;
    logic             phase_wrap;

    // tick is registered one count early so it is high exactly while div is all ones
    always_ff @(posedge CLK) begin
        if (!reset) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            div_reg  <= div_reg + DIV_W'(1);
            tick_reg <= (div_reg == DIV_PRE);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_reg;
            logic [DC_W-1:0] dcnt_reg;
            logic            pressed;

            assign pressed = ~sync2_reg;

            always_ff @(posedge CLK) begin
                if (!reset) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    deb_reg   <= 1'b0;
                    dcnt_reg  <= '0;
                end else begin
                    sync1_reg <= but_n[gi];
                    sync2_reg <= sync1_reg;
                    if (tick_reg) begin
                        if (pressed != deb_reg) begin
                            if (dcnt_reg == DEB_LAST) begin
                                deb_reg  <= pressed;
                                dcnt_reg <= '0;
                            end else begin
                                dcnt_reg <= dcnt_reg + DC_W'(1);
                            end
                        end else begin
                            dcnt_reg <= '0;
                        end
                    end
                end
            end

            assign deb_vec[gi] = deb_reg;
            assign alt_pat[gi] = phase_reg ^ 1'(gi % 2);
        end

        if (N_CH == 1) begin : g_rot_one
            assign chase_rot = chase_reg;
        end else begin : g_rot_many
            assign chase_rot = {chase_reg[N_CH-2:0], chase_reg[N_CH-1]};
        end
    endgenerate

    assign combo      = (&deb_vec) && (lock_cnt_reg == LOCK_FULL);
    assign phase_wrap = (phase_cnt_reg == PHASE_LAST);

    // A mode change restarts the pattern so every mode begins from a known phase
    always_ff @(posedge CLK) begin
        if (!reset) begin
            mode_reg      <= mode_t'(2'(RESET_MODE));
            lock_cnt_reg  <= '0;
            phase_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            chase_reg     <= CHASE_INIT;
        end else if (tick_reg) begin
            if (combo) begin
                mode_reg      <= mode_t'(mode_reg + 2'd1);
                lock_cnt_reg  <= '0;
                phase_cnt_reg <= '0;
                phase_reg     <= 1'b0;
                chase_reg     <= CHASE_INIT;
            end else begin
                if (lock_cnt_reg != LOCK_FULL) begin
                    lock_cnt_reg <= lock_cnt_reg + LK_W'(1);
                end
                if (phase_wrap) begin
                    phase_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                    chase_reg     <= chase_rot;
                end else begin
                    phase_cnt_reg <= phase_cnt_reg + PC_W'(1);
                end
            end
        end
    end

    always_comb begin
        led_next = '0;
        case (mode_reg)
            MODE_DIRECT:    led_next = deb_vec;
            MODE_ALTERNATE: led_next = alt_pat;
            MODE_CHASE:     led_next = chase_reg;
            MODE_ALL_BLINK: led_next = {N_CH{phase_reg}};
            default:        led_next = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign led  = led_reg;
    assign mode = mode_reg;
    assign tick = tick_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: hand-derived vector table from reset, then random
// button/reset stimulus compared every cycle against a tick-level reference model.
module tb_led_pattern_ctrl;

    localparam int N_CH          = 4;
    localparam int DIV_W         = 2;
    localparam int DEB_TICKS     = 3;
    localparam int HALF_TICKS    = 4;
    localparam int LOCKOUT_TICKS = 8;
    localparam int RESET_MODE    = 1;
    localparam int TICK_PERIOD   = 1 << DIV_W;

    logic            CLK = 1'b0;
    logic            reset = 1'b0;
    logic [N_CH-1:0] but_n = '1;
    logic [N_CH-1:0] led;
    logic [1:0]      mode;
    logic            tick;

    always #5 CLK = ~CLK;

    led_pattern_ctrl #(
        .N_CH(N_CH), .DIV_W(DIV_W), .DEB_TICKS(DEB_TICKS), .HALF_TICKS(HALF_TICKS),
        .LOCKOUT_TICKS(LOCKOUT_TICKS), .RESET_MODE(RESET_MODE)
    ) dut (
        .CLK(CLK), .reset(reset), .but_n(but_n), .led(led), .mode(mode), .tick(tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, in plain counts and positions
    int        m_cycle;
    logic [3:0] m_s1, m_s2, m_deb;
    int        m_dcnt [4];
    int        m_steps;
    bit        m_phase;
    int        m_pos;
    int        m_lock;
    int        m_mode;
    logic [3:0] m_led;

    function automatic logic [3:0] pattern();
        case (m_mode)
            0:       return m_deb;
            1:       return m_phase ? 4'b0101 : 4'b1010;
            2:       return 4'(1 << m_pos);
            default: return m_phase ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] pressed;
        logic [3:0] deb_old;
        if (!reset) begin
            m_cycle = 0; m_s1 = '1; m_s2 = '1; m_deb = '0;
            for (int i = 0; i < 4; i++) m_dcnt[i] = 0;
            m_steps = 0; m_phase = 0; m_pos = 0; m_lock = 0;
            m_mode = RESET_MODE; m_led = '0;
        end else begin
            pressed = ~m_s2;
            deb_old = m_deb;
            m_led   = pattern();
            if (m_cycle == TICK_PERIOD - 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (pressed[i] != m_deb[i]) begin
                        m_dcnt[i]++;
                        if (m_dcnt[i] == DEB_TICKS) begin
                            m_deb[i]  = pressed[i];
                            m_dcnt[i] = 0;
                        end
                    end else begin
                        m_dcnt[i] = 0;
                    end
                end
                if (deb_old == 4'b1111 && m_lock == LOCKOUT_TICKS) begin
                    m_mode = (m_mode + 1) % 4;
                    m_lock = 0; m_steps = 0; m_phase = 0; m_pos = 0;
                end else begin
                    if (m_lock < LOCKOUT_TICKS) m_lock++;
                    m_steps++;
                    if (m_steps == HALF_TICKS) begin
                        m_steps = 0;
                        m_phase = ~m_phase;
                        m_pos   = (m_pos + 1) % 4;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = but_n;
            m_cycle = (m_cycle + 1) % TICK_PERIOD;
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("model_led", led, m_led);
        check("model_mode", {2'b00, mode}, 4'(m_mode));
        check("model_tick", {3'b000, tick}, {3'b000, m_cycle == TICK_PERIOD - 1});
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] but;
        int         cyc;
        logic [3:0] led;
        logic [1:0] mode;
        logic       tick;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] b, input int c,
                       input logic [3:0] l, input logic [1:0] m, input logic t);
        vec_t v;
        v.rst = r; v.but = b; v.cyc = c; v.led = l; v.mode = m; v.tick = t;
        tbl.push_back(v);
    endtask

    initial begin
        // Edge counts in comments are posedges since reset release
        add(1'b0, 4'b0000,  5, 4'b0000, 2'd1, 1'b0); // reset held, combo held
        add(1'b1, 4'b0000,  1, 4'b1010, 2'd1, 1'b0); // P1
        add(1'b1, 4'b0000,  2, 4'b1010, 2'd1, 1'b1); // P3 first tick
        add(1'b1, 4'b0000,  4, 4'b1010, 2'd1, 1'b1); // P7
        add(1'b1, 4'b0000,  4, 4'b1010, 2'd1, 1'b1); // P11
        add(1'b1, 4'b0000,  5, 4'b1010, 2'd1, 1'b0); // P16
        add(1'b1, 4'b0000,  1, 4'b0101, 2'd1, 1'b0); // P17 toggle after 4 ticks
        add(1'b1, 4'b0000, 16, 4'b1010, 2'd1, 1'b0); // P33 toggle after 8 ticks
        add(1'b1, 4'b0000,  3, 4'b1010, 2'd2, 1'b0); // P36 lockout expires
        add(1'b1, 4'b0000,  1, 4'b0001, 2'd2, 1'b0); // P37 chase start
        add(1'b1, 4'b0000, 35, 4'b0100, 2'd3, 1'b0); // P72 repeat after 9 ticks
        add(1'b1, 4'b0000,  1, 4'b0000, 2'd3, 1'b0); // P73
        add(1'b1, 4'b0000, 16, 4'b1111, 2'd3, 1'b0); // P89
        add(1'b1, 4'b0000, 18, 4'b0000, 2'd3, 1'b1); // P107
        add(1'b1, 4'b0000,  1, 4'b0000, 2'd0, 1'b0); // P108 wrap to direct
        add(1'b1, 4'b0000,  1, 4'b1111, 2'd0, 1'b0); // P109
        add(1'b1, 4'b1111, 11, 4'b1111, 2'd0, 1'b0); // P120 release in progress
        add(1'b1, 4'b1111,  1, 4'b0000, 2'd0, 1'b0); // P121
        add(1'b1, 4'b1011,  8, 4'b0000, 2'd0, 1'b0); // P129 2-tick glitch
        add(1'b1, 4'b1111, 12, 4'b0000, 2'd0, 1'b0); // P141 glitch ignored
        add(1'b1, 4'b1011, 11, 4'b0000, 2'd0, 1'b0); // P152 two ticks counted
        add(1'b1, 4'b1011,  1, 4'b0100, 2'd0, 1'b0); // P153 third tick accepted
        add(1'b1, 4'b1111, 11, 4'b0100, 2'd0, 1'b0); // P164
        add(1'b1, 4'b1111,  1, 4'b0000, 2'd0, 1'b0); // P165 release accepted
        add(1'b1, 4'b0000, 15, 4'b1111, 2'd1, 1'b0); // P180 lockout already full
        add(1'b1, 4'b0000, 36, 4'b1010, 2'd2, 1'b0); // P216
        add(1'b1, 4'b1111,  1, 4'b0001, 2'd2, 1'b0); // P217
        add(1'b1, 4'b1111, 32, 4'b0100, 2'd2, 1'b0); // P249
        add(1'b1, 4'b1110,  8, 4'b0100, 2'd2, 1'b0); // P257 partial debounce
        add(1'b0, 4'b1110,  1, 4'b0000, 2'd1, 1'b0); // reset mid-chase
        add(1'b1, 4'b1110,  3, 4'b1010, 2'd1, 1'b1); // prescaler restarted
        add(1'b1, 4'b1110,  1, 4'b1010, 2'd1, 1'b0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            but_n = tbl[i].but;
            repeat (tbl[i].cyc) cycle();
            check($sformatf("vec%0d_led", i), led, tbl[i].led);
            check($sformatf("vec%0d_mode", i), {2'b00, mode}, {2'b00, tbl[i].mode});
            check($sformatf("vec%0d_tick", i), {3'b000, tick}, {3'b000, tbl[i].tick});
            $display("vec %0d: reset=%b but_n=%b led=%b mode=%0d tick=%b",
                     i, reset, but_n, led, mode, tick);
        end

        for (int seg = 0; seg < 300; seg++) begin
            int r;
            int hold;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                reset = 1'b0;
                hold  = $urandom_range(1, 3);
            end else begin
                reset = 1'b1;
                r = $urandom_range(0, 99);
                if (r < 40) begin
                    but_n = 4'b0000;
                    hold  = $urandom_range(1, 140);
                end else if (r < 70) begin
                    but_n = 4'($urandom);
                    hold  = $urandom_range(1, 20);
                end else begin
                    but_n = 4'b1111;
                    hold  = $urandom_range(1, 40);
                end
            end
            repeat (hold) cycle();
            $display("seg %0d: reset=%b but_n=%b hold=%0d led=%b mode=%0d",
                     seg, reset, but_n, hold, led, mode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
